// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-locked arbiter sharing one write port
// of the CNN async FIFO among NUM_REQ producers, in the write-clock domain.
// A single registered output stage drives wr_en/wr_data and honours the
// FIFO full flag, so an accepted beat is never dropped.
// Optional statistics counters are enabled by defining FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int width     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                       wr_clk,
    input  logic                       rest_n,
    input  logic [NUM_REQ-1:0]         req_vld,
    input  logic [NUM_REQ*width-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_rdy,
    input  logic                       full,
    output logic                       wr_en,
    output logic [width-1:0]           wr_data,
    output logic [$clog2(NUM_REQ)-1:0] gnt_id,
    output logic                       busy
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    output logic [15:0]                stall_cnt,
    output logic [15:0]                beat_cnt_total
`endif
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   gnt_id_q, gnt_id_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]    beat_cnt_q, beat_cnt_d;
    logic             wr_en_q, wr_en_d;
    logic [width-1:0] wr_data_q, wr_data_d;

    logic             load;
    logic             grant_vld;
    logic             handshake;
    logic [width-1:0] gnt_data;
    logic             pick_found;
    logic [IDW-1:0]   pick_id;
    logic [IDW-1:0]   cand;

    assign load      = ~wr_en_q | ~full;
    assign grant_vld = req_vld[gnt_id_q];
    assign handshake = (state_q == BURST) && load && grant_vld;
    assign gnt_data  = req_data[int'(gnt_id_q)*width +: width];

    // Round-robin pick: first valid requester after rr_ptr, wrapping around.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        cand       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDW'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!pick_found && req_vld[cand]) begin
                pick_found = 1'b1;
                pick_id    = cand;
            end
        end
    end

    // Next-state, output stage loading and ready generation.
    always_comb begin
        state_d    = state_q;
        gnt_id_d   = gnt_id_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        wr_en_d    = wr_en_q;
        wr_data_d  = wr_data_q;
        req_rdy    = '0;

        if ((state_q == BURST) && load) begin
            req_rdy[gnt_id_q] = 1'b1;
        end

        if (load) begin
            wr_en_d   = handshake;
            wr_data_d = gnt_data;
        end

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    gnt_id_d   = pick_id;
                    beat_cnt_d = '0;
                    state_d    = BURST;
                end
            end
            BURST: begin
                if (load) begin
                    if (grant_vld) begin
                        beat_cnt_d = beat_cnt_q + CW'(1);
                        if (beat_cnt_q == CW'(MAX_BURST - 1)) begin
                            state_d  = IDLE;
                            rr_ptr_d = gnt_id_q;
                        end
                    end else begin
                        state_d  = IDLE;
                        rr_ptr_d = gnt_id_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output register with synchronous active-low reset.
    always_ff @(posedge wr_clk) begin
        if (!rest_n) begin
            state_q    <= IDLE;
            gnt_id_q   <= '0;
            rr_ptr_q   <= IDW'(NUM_REQ - 1);
            beat_cnt_q <= '0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            gnt_id_q   <= gnt_id_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_data = wr_data_q;
    assign gnt_id  = gnt_id_q;
    assign busy    = (state_q == BURST);

`ifdef FIFO_WR_ARB_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] beat_total_q, beat_total_d;

    // Saturating full-stall counter and wrapping accepted-beat counter.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        beat_total_d = beat_total_q;
        if (wr_en_q && full && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (wr_en_q && !full) begin
            beat_total_d = beat_total_q + 16'd1;
        end
    end

    // Statistics registers, cleared by reset.
    always_ff @(posedge wr_clk) begin
        if (!rest_n) begin
            stall_cnt_q  <= '0;
            beat_total_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            beat_total_q <= beat_total_d;
        end
    end

    assign stall_cnt      = stall_cnt_q;
    assign beat_cnt_total = beat_total_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: scoreboard bench for fifo_wr_arbiter. A transaction-level
// reference model predicts grants, ready and the accepted beat stream; a
// separate monitor pops expected beats whenever the FIFO accepts one.
// Statistics outputs are compared when FIFO_WR_ARB_STATS_EN is defined.
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int W         = 8;
    localparam int MAX_BURST = 4;
    localparam int N_CYCLES  = 1600;

    logic                 wr_clk = 1'b0;
    logic                 rest_n;
    logic [NUM_REQ-1:0]   req_vld;
    logic [NUM_REQ*W-1:0] req_data;
    logic [NUM_REQ-1:0]   req_rdy;
    logic                 full;
    logic                 wr_en;
    logic [W-1:0]         wr_data;
    logic [1:0]           gnt_id;
    logic                 busy;
`ifdef FIFO_WR_ARB_STATS_EN
    logic [15:0]          stall_cnt;
    logic [15:0]          beat_cnt_total;
`endif

    fifo_wr_arbiter #(.NUM_REQ(NUM_REQ), .width(W), .MAX_BURST(MAX_BURST)) dut (
        .wr_clk   (wr_clk),
        .rest_n   (rest_n),
        .req_vld  (req_vld),
        .req_data (req_data),
        .req_rdy  (req_rdy),
        .full     (full),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .gnt_id   (gnt_id),
        .busy     (busy)
`ifdef FIFO_WR_ARB_STATS_EN
        ,
        .stall_cnt      (stall_cnt),
        .beat_cnt_total (beat_cnt_total)
`endif
    );

    // Free-running write clock.
    always #5 wr_clk = ~wr_clk;

    int checks = 0;
    int passed = 0;

    // Reference model state: grant owner, beats taken, last winner, output reg.
    bit         m_busy;
    int         m_gnt;
    int         m_cnt;
    int         m_ptr;
    bit         m_wr_en;
    logic [7:0] m_wr_data;
    int         m_stall;
    int         m_total;
    logic [7:0] exp_q[$];

    // Producer state and stimulus knobs.
    int               rem[NUM_REQ];
    logic [7:0]       dval[NUM_REQ];
    logic [NUM_REQ-1:0] hs_mask;
    int               vld_prob;
    int               full_prob;
    int               rst_prob;
    bit               force_full;
    bit               force_rst;
    bit               refill;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    task automatic modelReset();
        m_busy    = 0;
        m_gnt     = 0;
        m_cnt     = 0;
        m_ptr     = NUM_REQ - 1;
        m_wr_en   = 0;
        m_wr_data = '0;
        m_stall   = 0;
        m_total   = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic modelStep();
        bit load;
        bit hs;
        if (!rest_n) begin
            if (m_wr_en && !full) begin
                while (exp_q.size() > 1) void'(exp_q.pop_back());
            end else begin
                exp_q.delete();
            end
            modelReset();
            return;
        end
        load = !m_wr_en || !full;
        if (m_wr_en && full && m_stall < 65535) m_stall++;
        if (m_wr_en && !full) m_total = (m_total + 1) % 65536;
        hs = m_busy && load && req_vld[m_gnt];
        if (hs) exp_q.push_back(req_data[m_gnt*W +: W]);
        if (load) begin
            m_wr_en   = hs;
            m_wr_data = req_data[m_gnt*W +: W];
        end
        if (!m_busy) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                if (req_vld[(m_ptr + k) % NUM_REQ]) begin
                    m_gnt  = (m_ptr + k) % NUM_REQ;
                    m_cnt  = 0;
                    m_busy = 1;
                    break;
                end
            end
        end else if (load) begin
            if (req_vld[m_gnt]) begin
                m_cnt++;
                if (m_cnt == MAX_BURST) begin
                    m_busy = 0;
                    m_ptr  = m_gnt;
                end
            end else begin
                m_busy = 0;
                m_ptr  = m_gnt;
            end
        end
    endtask

    // Scenario schedule: single requester, all busy, full stall, reset, drop, random, drain.
    task automatic setPhase(input int c);
        force_rst  = (c == 0) || (c == 75);
        force_full = (c >= 60 && c < 65);
        if (c == 1) begin
            rem[2] = 6; dval[2] = 8'h10;
            vld_prob = 100; full_prob = 0; rst_prob = 0; refill = 0;
        end
        if (c == 30) for (int i = 0; i < NUM_REQ; i++) rem[i] = 40;
        if (c == 100) begin
            rem[0] = 5; rem[1] = 2; rem[2] = 0; rem[3] = 5;
        end
        if (c == 130) begin
            vld_prob = 70; full_prob = 25; rst_prob = 3; refill = 1;
        end
        if (c == N_CYCLES - 50) begin
            vld_prob = 0; full_prob = 0; rst_prob = 0; refill = 0;
        end
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (hs_mask[i]) begin
                rem[i]--;
                dval[i]++;
            end
            if (refill && rem[i] <= 0 && $urandom_range(9) == 0) rem[i] = $urandom_range(8, 1);
            req_vld[i] = (rem[i] > 0) && ($urandom_range(99) < vld_prob);
            req_data[i*W +: W] = dval[i];
        end
        full   = force_full || ($urandom_range(99) < full_prob);
        rest_n = !(force_rst || ($urandom_range(999) < rst_prob));
    endtask

    task automatic checkOutput();
        logic [NUM_REQ-1:0] exp_rdy;
        bit load;
        load    = !m_wr_en || !full;
        exp_rdy = (m_busy && load) ? 4'(1 << m_gnt) : 4'd0;
        check("req_rdy", req_rdy, exp_rdy);
        check("wr_en", wr_en, m_wr_en);
        if (m_wr_en) check("wr_data_reg", wr_data, m_wr_data);
        check("gnt_id", gnt_id, m_gnt);
        check("busy", busy, m_busy);
`ifdef FIFO_WR_ARB_STATS_EN
        check("stall_cnt", stall_cnt, m_stall);
        check("beat_cnt_total", beat_cnt_total, m_total);
`endif
        hs_mask = req_vld & req_rdy;
        modelStep();
    endtask

    // Monitor: every beat the FIFO accepts must be the oldest expected beat.
    initial begin
        forever begin
            @(negedge wr_clk);
            #2;
            if (wr_en === 1'b1 && full === 1'b0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL beat_unexpected: got %0h expected none at %0t", wr_data, $time);
                end else begin
                    check("fifo_beat", wr_data, exp_q.pop_front());
                end
            end
        end
    end

    // Stimulus driver and per-cycle model comparison.
    initial begin
        rest_n = 1'b0; full = 1'b0; req_vld = '0; req_data = '0; hs_mask = '0;
        vld_prob = 100; full_prob = 0; rst_prob = 0; refill = 0;
        force_full = 0; force_rst = 1;
        for (int i = 0; i < NUM_REQ; i++) begin
            rem[i]  = 0;
            dval[i] = 8'(i * 8'h40);
        end
        modelReset();
        repeat (2) @(posedge wr_clk);
        for (int c = 0; c < N_CYCLES; c++) begin
            @(negedge wr_clk);
            setPhase(c);
            applyStimulus();
            #1;
            checkOutput();
        end
        @(negedge wr_clk);
        #3;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
